// File: rtl/ps2_tx.sv
//==============================================================================
// Module   : ps2_tx
// Brief    : Host-to-device PS/2 command transmitter with ps2c glitch filter
//            and an inter-edge watchdog that aborts a stalled frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       timeout_tick
);

    localparam int c_rts_w = $clog2(RTS_CYCLES + 1);
    localparam int c_wd_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_rts_w-1:0] c_rts_last = c_rts_w'(RTS_CYCLES - 1);
    localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_rts   = 3'd1;
    localparam logic [2:0] c_st_req   = 3'd2;
    localparam logic [2:0] c_st_start = 3'd3;
    localparam logic [2:0] c_st_data  = 3'd4;
    localparam logic [2:0] c_st_stop  = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;
    localparam logic [2:0] c_st_abort = 3'd7;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_fclk;
    logic                  w_fall;
    logic [8:0]            r_frame;
    logic [3:0]            r_bits;
    logic                  r_dout;
    logic [c_rts_w-1:0]    r_rts_cnt;
    logic [c_wd_w-1:0]     r_wd;
    logic                  r_ack_err;
    logic                  w_wd_active;
    logic                  w_wd_expired;

    // Filtered clock only moves on a unanimous window; mixed windows hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_sr <= '1;
            r_fclk    <= 1'b1;
        end else begin
            r_filt_sr <= {ps2c_in, r_filt_sr[FILTER_LEN-1:1]};
            if (&r_filt_sr)
                r_fclk <= 1'b1;
            else if (~|r_filt_sr)
                r_fclk <= 1'b0;
        end
    end

    assign w_fall       = r_fclk & ~|r_filt_sr;
    assign w_wd_active  = (r_state == c_st_start) || (r_state == c_st_data) ||
                          (r_state == c_st_stop);
    assign w_wd_expired = w_wd_active && (r_wd == c_wd_last);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    // A device edge arriving in the expiry cycle wins over the abort.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (wr_ps2) w_state_next = c_st_rts;
            c_st_rts:   if (r_rts_cnt == c_rts_last) w_state_next = c_st_req;
            c_st_req:   w_state_next = c_st_start;
            c_st_start: if (w_fall) w_state_next = c_st_data;
                        else if (w_wd_expired) w_state_next = c_st_abort;
            c_st_data:  if (w_fall && (r_bits == 4'd0)) w_state_next = c_st_stop;
                        else if (!w_fall && w_wd_expired) w_state_next = c_st_abort;
            c_st_stop:  if (w_fall) w_state_next = c_st_done;
                        else if (w_wd_expired) w_state_next = c_st_abort;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        ps2c_oe      = 1'b0;
        ps2d_oe      = 1'b0;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        timeout_tick = 1'b0;
        case (r_state)
            c_st_idle:  tx_idle = 1'b1;
            c_st_rts:   ps2c_oe = 1'b1;
            c_st_req:   begin ps2c_oe = 1'b1; ps2d_oe = 1'b1; end
            c_st_start: ps2d_oe = 1'b1;
            c_st_data:  ps2d_oe = ~r_dout;
            c_st_done:  tx_done_tick = 1'b1;
            c_st_abort: timeout_tick = 1'b1;
            default:    ;
        endcase
    end

    // r_dout holds the bit currently on the line; r_frame already points past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame   <= '0;
            r_bits    <= '0;
            r_dout    <= 1'b1;
            r_rts_cnt <= '0;
            r_wd      <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_rts_cnt <= (r_state == c_st_rts) ? r_rts_cnt + c_rts_w'(1) : '0;

            if ((r_state == c_st_req) || w_fall)
                r_wd <= '0;
            else if (w_wd_active)
                r_wd <= r_wd + c_wd_w'(1);
            else
                r_wd <= '0;

            case (r_state)
                c_st_idle: if (wr_ps2) begin
                    r_frame   <= {~^din, din};
                    r_bits    <= 4'd8;
                    r_ack_err <= 1'b0;
                end
                c_st_start: if (w_fall) begin
                    r_dout  <= r_frame[0];
                    r_frame <= {1'b0, r_frame[8:1]};
                end
                c_st_data: if (w_fall && (r_bits != 4'd0)) begin
                    r_dout  <= r_frame[0];
                    r_frame <= {1'b0, r_frame[8:1]};
                    r_bits  <= r_bits - 4'd1;
                end
                c_st_stop: if (w_fall) r_ack_err <= ps2d_in;
                default: ;
            endcase
        end
    end

    assign ack_err = r_ack_err;

endmodule

`default_nettype wire
